// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the Zicsr counter-access path: counter CSR addresses,
// funct3 encodings, sequencer state enum, counter-select enum, the decoded
// operation struct and a helper that classifies an access as a write (or an
// unused encoding).
// -----------------------------------------------------------------------------
package csr_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned XLEN       = 32;

    // Zicntr user-level counter addresses
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    // Zicsr funct3 encodings
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } csr_state_e;

    typedef enum logic [1:0] {
        CNTR_NONE    = 2'd0,
        CNTR_CYCLE   = 2'd1,
        CNTR_TIME    = 2'd2,
        CNTR_INSTRET = 2'd3
    } cntr_sel_e;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [4:0]  rs1_idx;
        logic [11:0] addr;
    } csr_op_t;

    // True when the instruction would modify its CSR, or when funct3 is not a
    // Zicsr encoding at all. Set/clear forms with rs1/zimm == 0 are pure reads.
    function automatic logic op_not_read_only(input logic [2:0] funct3,
                                              input logic [4:0] rs1_idx);
        logic bad;
        case (funct3)
            F3_RW, F3_RWI:                bad = 1'b1;
            F3_RS, F3_RC, F3_RSI, F3_RCI: bad = (rs1_idx != 5'd0);
            default:                      bad = 1'b1;  // 000 / 100
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// -----------------------------------------------------------------------------
// csr_access_unit_if
// Request/response bundle between the execute stage and csr_access_unit.
//   req_valid/req_ready       : request handshake (master -> unit)
//   req_funct3/csr_addr/rs1_* : decoded CSR instruction fields
//   resp_valid/resp_ready     : response handshake (unit -> writeback)
//   resp_rdata/resp_illegal   : value for rd and illegal-instruction flag
// master = pipeline side, slave = csr_access_unit.
// -----------------------------------------------------------------------------
interface csr_access_unit_if;
    import csr_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_funct3;
    logic [CSR_ADDR_W-1:0] req_csr_addr;
    logic [4:0]            req_rs1_idx;
    logic [XLEN-1:0]       req_rs1_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_data,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_data,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_illegal
    );

endinterface

// File: rtl/csr_access_unit_checker.sv
// -----------------------------------------------------------------------------
// csr_access_unit_checker
// Protocol checks for csr_access_unit.
//   clk, reset_n  : clock and synchronous active-low reset
//   other_retire  : non-CSR retirement from the pipeline
//   csr_retire    : CSR instruction retiring through the response handshake
// Two retirements in one cycle would lose an instret increment.
// -----------------------------------------------------------------------------
module csr_access_unit_checker (
    input logic clk,
    input logic reset_n,
    input logic other_retire,
    input logic csr_retire
);

    a_single_retire: assert property (
        @(posedge clk) disable iff (!reset_n) !(other_retire && csr_retire)
    );

endmodule

// File: rtl/csr_legality_check.sv
// -----------------------------------------------------------------------------
// csr_legality_check
// Combinational legality decode for a counter CSR access.
//   addr_i      : CSR address
//   funct3_i    : Zicsr funct3
//   rs1_idx_i   : rs1 index / zimm
//   illegal_o   : access must raise illegal-instruction
//   cntr_sel_o  : which counter pair the address maps to (CNTR_NONE if none)
// CNTR_ACCESS_MASK: bit0 cycle, bit1 time, bit2 instret readable.
// -----------------------------------------------------------------------------
module csr_legality_check
    import csr_pkg::*;
#(
    parameter logic [2:0] CNTR_ACCESS_MASK = 3'b111
) (
    input  logic [11:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_idx_i,
    output logic        illegal_o,
    output cntr_sel_e   cntr_sel_o
);

    cntr_sel_e sel_s;
    logic      mask_ok_s;

    // Map address to counter pair, then gate by the access mask and op type
    always_comb begin
        sel_s     = CNTR_NONE;
        mask_ok_s = 1'b0;
        case (addr_i)
            CSR_CYCLE,   CSR_CYCLEH:   sel_s = CNTR_CYCLE;
            CSR_TIME,    CSR_TIMEH:    sel_s = CNTR_TIME;
            CSR_INSTRET, CSR_INSTRETH: sel_s = CNTR_INSTRET;
            default:                   sel_s = CNTR_NONE;
        endcase
        case (sel_s)
            CNTR_CYCLE:   mask_ok_s = CNTR_ACCESS_MASK[0];
            CNTR_TIME:    mask_ok_s = CNTR_ACCESS_MASK[1];
            CNTR_INSTRET: mask_ok_s = CNTR_ACCESS_MASK[2];
            default:      mask_ok_s = 1'b0;  // unknown address
        endcase
        illegal_o  = ~mask_ok_s | op_not_read_only(funct3_i, rs1_idx_i);
        cntr_sel_o = sel_s;
    end

endmodule

// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
// Execute-stage sequencer for Zicsr reads of the Zicntr counters.
//   clk, reset_n              : clock, synchronous active-low reset
//   bus (slave)               : request / response handshakes (see _if)
//   csr_addr                  : registered address to the counter file
//   csr_content               : combinational read data from the counter file
//   other_retire              : a non-CSR instruction retires this cycle
//   disable_instret_increment : to counter file, low when anything retires
// Flow: IDLE (accept, decode legality) -> CAPTURE (sample counter) -> RESP
// (hold result until writeback takes it). One instruction at a time.
// -----------------------------------------------------------------------------
module csr_access_unit
    import csr_pkg::*;
#(
    parameter logic [2:0] CNTR_ACCESS_MASK = 3'b111
) (
    input  logic                  clk,
    input  logic                  reset_n,
    csr_access_unit_if.slave      bus,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]       csr_content,
    input  logic                  other_retire,
    output logic                  disable_instret_increment
);

    csr_state_e      state_q,      state_d;
    csr_op_t         op_q,         op_d;
    logic            legal_q,      legal_d;
    logic [XLEN-1:0] rdata_q,      rdata_d;
    logic            illegal_q,    illegal_d;
    logic            req_ready_q,  req_ready_d;
    logic            resp_valid_q, resp_valid_d;

    logic            chk_illegal_s;
    cntr_sel_e       chk_sel_s;
    logic            csr_retire_s;
    logic            unused_bits_s;

    csr_legality_check #(
        .CNTR_ACCESS_MASK (CNTR_ACCESS_MASK)
    ) u_legality (
        .addr_i     (bus.req_csr_addr),
        .funct3_i   (bus.req_funct3),
        .rs1_idx_i  (bus.req_rs1_idx),
        .illegal_o  (chk_illegal_s),
        .cntr_sel_o (chk_sel_s)
    );

    // Next-state and output-register logic of the three-step sequencer
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        legal_d      = legal_q;
        rdata_d      = rdata_q;
        illegal_d    = illegal_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d     = ST_CAPTURE;
                    op_d        = '{funct3:  bus.req_funct3,
                                    rs1_idx: bus.req_rs1_idx,
                                    addr:    bus.req_csr_addr};
                    legal_d     = ~chk_illegal_s;
                    req_ready_d = 1'b0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Illegal accesses never expose counter data
                if (legal_q) begin
                    rdata_d = csr_content;
                end else begin
                    rdata_d = 32'h0000_0000;
                end
                illegal_d    = ~legal_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '{funct3: 3'b000, rs1_idx: 5'd0, addr: 12'h000};
            legal_q      <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            illegal_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            legal_q      <= legal_d;
            rdata_q      <= rdata_d;
            illegal_q    <= illegal_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign csr_addr         = op_q.addr;
    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_illegal = illegal_q;

    // A legal CSR read retires when writeback takes it; an illegal one traps
    assign csr_retire_s = resp_valid_q & bus.resp_ready & ~illegal_q;
    assign disable_instret_increment = ~(other_retire | csr_retire_s);

    // rs1 data is never needed (all targets are read-only); funct3/rs1 are
    // latched for trace visibility and counter select is for later M-mode use
    assign unused_bits_s = ^{bus.req_rs1_data, op_q.funct3, op_q.rs1_idx,
                             chk_sel_s};

    csr_access_unit_checker u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .other_retire (other_retire),
        .csr_retire   (csr_retire_s)
    );

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Execute-stage sequencer for Zicsr instructions that target the Zicntr counters. It accepts one decoded CSR instruction, drives the counter file's 12-bit address port, captures its 32-bit read data, and flags illegal accesses. It returns the result to writeback over a valid/ready handshake. It also generates the counter file's `disable_instret_increment` input from retirement events.

## Interface
Parameters:
- `CNTR_ACCESS_MASK`, default 3'b111: bit0 = cycle/cycleh, bit1 = time/timeh, bit2 = instret/instreth readable; a cleared bit makes that pair illegal.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `req_valid`  in  1  — CSR instruction offered.
- `req_ready`  out  1  — unit can accept.
- `req_funct3`  in  3  — 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `req_csr_addr`  in  12  — CSR address from instruction.
- `req_rs1_idx`  in  5  — rs1 index, or zimm for immediate forms.
- `req_rs1_data`  in  32  — rs1 value; unused because all targets are read-only.
- `csr_addr`  out  12  — to counter file, registered.
- `csr_content`  in  32  — combinational read data from counter file.
- `resp_valid`  out  1  — result available.
- `resp_ready`  in  1  — writeback accepts.
- `resp_rdata`  out  32  — value for rd.
- `resp_illegal`  out  1  — raise illegal-instruction exception.
- `other_retire`  in  1  — a non-CSR instruction retires this cycle.
- `disable_instret_increment`  out  1  — to counter file.

## Operation
- FSM states: IDLE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch funct3, rs1_idx and legality; load `csr_addr` ← `req_csr_addr`; go to CAPTURE.
- CAPTURE:
  - `req_ready`=0.
  - Sample `csr_content` into `resp_rdata` if legal, else 0.
  - Set `resp_illegal`; go to RESP.
- RESP:
  - `resp_valid`=1; `resp_rdata`/`resp_illegal` held stable.
  - On `resp_ready`: go to IDLE.
- Legality is evaluated in IDLE at accept. An access is illegal if any of the following holds:
  - address is not one of C00, C01, C02, C80, C81, C82;
  - the matching `CNTR_ACCESS_MASK` bit is 0;
  - the instruction writes: funct3 ∈ {001, 101}, or funct3 ∈ {010, 011, 110, 111} with `req_rs1_idx` ≠ 0;
  - funct3 ∈ {000, 100}.
- `csr_addr` keeps its last value while not in CAPTURE; the counter file is read only in CAPTURE.
- Retirement:
  - `csr_retire` = `resp_valid & resp_ready & ~resp_illegal`.
  - `disable_instret_increment` = `~(other_retire | csr_retire)`, combinational.
  - `other_retire` and `csr_retire` both high in one cycle is a protocol violation. It still counts as one increment, and a simulation assertion fires.

## Timing
- Reset (`reset_n`=0 at edge): state IDLE, `csr_addr`=12'h000, `resp_rdata`=0, `resp_illegal`=0. `resp_valid`=0 and `req_ready`=1 on the next cycle. `disable_instret_increment` follows its equation: it is 1 unless `other_retire`=1.
- Reset mid-operation drops the in-flight request with no response.
- Latency from request accept edge to `resp_valid` high is 2 cycles.
- Minimum occupancy is 3 cycles per instruction; `req_ready` is 0 from CAPTURE until RESP completes.
- The sampled counter value is the one visible in the CAPTURE cycle, i.e. the counter state one cycle after accept.
- Backpressure: in RESP with `resp_ready`=0, all outputs hold indefinitely.
- `req_*` inputs are don't-care except at the IDLE accept edge.

## Structure
- Package `csr_pkg`:
  - the six counter addresses;
  - funct3 encodings;
  - the FSM state enum (IDLE/CAPTURE/RESP);
  - a `csr_op_t` struct {funct3, rs1_idx, addr}.
- Sub-module `csr_legality_check`: combinational; inputs addr, funct3, rs1_idx and the mask parameter; outputs illegal and counter-select. It is reused by later machine-mode CSR work.

## Test plan
- Reset, then CSRRS x0 from C00 (rs1=0): `resp_valid` 2 cycles after accept; `resp_rdata` = cycle count in CAPTURE (3 if accept is the 2nd cycle after reset release); `resp_illegal`=0; `disable_instret_increment`=0 in the handshake cycle.
- CSRRW to C02: `resp_illegal`=1, `resp_rdata`=0; `disable_instret_increment` stays 1 in the handshake cycle.
- CSRRSI C81 with zimm=5: illegal. CSRRSI C81 with zimm=0: legal, returns `time_reg[63:32]`. Preload the time counter at 0xFFFF_FFFF low half so the upper half is seen to increment.
- Hold `resp_ready`=0 for 10 cycles in RESP: outputs stable, `req_ready`=0, a new `req_valid` is ignored; release returns to IDLE and accepts next cycle.
- `CNTR_ACCESS_MASK`=3'b011, read C82: illegal. Read C00: legal.
- Deassert `reset_n` in CAPTURE: next cycle IDLE with `resp_valid`=0; no response ever issued for the dropped request.
